// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the register scoreboard and its neighbours
// in ID (forwarding and hazard logic).
package reg_scoreboard_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int LAT_W_DEF   = 3;
    localparam int NUM_REGS_DEF = 32;
    localparam int CNT_W_DEF   = 32;

    // Producer latencies: cycles after issue before rd can be bypassed.
    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // A source operand is hazardous only if it is read, is not x0, and its
    // producer is still counting down.
    function automatic logic src_hazard(input logic use_en,
                                        input reg_idx_t idx,
                                        input logic pending);
        return use_en && (idx != '0) && pending;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID-stage view of the scoreboard: decoded operand info in, stall and
// status out.
interface reg_scoreboard_if
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int LAT_W    = LAT_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
);

    logic                id_valid;
    logic                id_flush;
    reg_idx_t            id_rs1;
    logic                id_rs1_use;
    reg_idx_t            id_rs2;
    logic                id_rs2_use;
    reg_idx_t            id_rd;
    logic                id_reg_write;
    logic [LAT_W-1:0]    id_lat;

    logic                stall;
    logic [NUM_REGS-1:0] pending_mask;
    logic                drained;
    logic [CNT_W-1:0]    stall_cycles;

    // Decode side drives the instruction and consumes the stall.
    modport master (
        output id_valid, id_flush, id_rs1, id_rs1_use, id_rs2, id_rs2_use,
               id_rd, id_reg_write, id_lat,
        input  stall, pending_mask, drained, stall_cycles
    );

    modport slave (
        input  id_valid, id_flush, id_rs1, id_rs1_use, id_rs2, id_rs2_use,
               id_rd, id_reg_write, id_lat,
        output stall, pending_mask, drained, stall_cycles
    );

endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// One register's pending-write countdown: load on issue, otherwise count
// down to zero and hold there.
module sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic             pending
);

    logic [LAT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every entry
    // samples the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - LAT_W'(1);
        end
    end

    assign pending = (count != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Producer-side scoreboard: tracks cycles until each register write becomes
// forwardable and stalls ID consumers that would read it too early.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int LAT_W    = LAT_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    reg_scoreboard_if.slave  sb
);

    logic [NUM_REGS-1:0] pending;
    logic                hz1;
    logic                hz2;
    logic                stall;
    logic                issue;
    logic [CNT_W-1:0]    stall_cnt;

    // x0 is hardwired; it never has a producer in flight.
    assign pending[0] = 1'b0;

    // NOTE: the counters are real state that must be trustworthy straight out
    // of reset, so they are cleared asynchronously rather than left to
    // power-up values like a data RAM.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic load;

        // Issue wins over decrement, so a younger WAW producer replaces the
        // older latency even when it is shorter.
        assign load = issue && sb.id_reg_write && (sb.id_rd == reg_idx_t'(r));

        sb_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .load_val (sb.id_lat),
            .pending  (pending[r])
        );
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        hz1   = 1'b0;
        hz2   = 1'b0;
        stall = 1'b0;
        issue = 1'b0;
        // Pre-update counters: an instruction never stalls on its own rd.
        hz1   = src_hazard(sb.id_rs1_use, sb.id_rs1, pending[sb.id_rs1]);
        hz2   = src_hazard(sb.id_rs2_use, sb.id_rs2, pending[sb.id_rs2]);
        stall = sb.id_valid && !sb.id_flush && (hz1 || hz2);
        issue = sb.id_valid && !sb.id_flush && !stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign sb.stall        = stall;
    assign sb.pending_mask = pending;
    assign sb.drained      = ~|pending;
    assign sb.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios followed by
// random traffic, all compared against a countdown-array model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    localparam int NUM_REGS = 32;
    localparam int LAT_W    = 3;
    localparam int CNT_W    = 6;
    localparam int SC_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_scoreboard_if #(.NUM_REGS(NUM_REGS), .LAT_W(LAT_W), .CNT_W(CNT_W)) sb_if ();

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .LAT_W    (LAT_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    // Reference model: cycles remaining until each register is forwardable.
    int cnt [NUM_REGS];
    int sc;
    int checks = 0;
    int errors = 0;

    // Copies of the current ID inputs, as the model sees them.
    logic in_v, in_f, in_u1, in_u2, in_w;
    int   in_rs1, in_rs2, in_rd, in_lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) cnt[r] = 0;
        sc = 0;
    endtask

    task automatic drive(input logic v, input logic f,
                         input int rs1, input logic u1,
                         input int rs2, input logic u2,
                         input int rd, input logic w, input int lat);
        in_v = v; in_f = f; in_rs1 = rs1; in_u1 = u1; in_rs2 = rs2; in_u2 = u2;
        in_rd = rd; in_w = w; in_lat = lat;
        sb_if.id_valid     = v;
        sb_if.id_flush     = f;
        sb_if.id_rs1       = reg_idx_t'(rs1);
        sb_if.id_rs1_use   = u1;
        sb_if.id_rs2       = reg_idx_t'(rs2);
        sb_if.id_rs2_use   = u2;
        sb_if.id_rd        = reg_idx_t'(rd);
        sb_if.id_reg_write = w;
        sb_if.id_lat       = lat[LAT_W-1:0];
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    // One cycle: check combinational outputs mid-cycle, then advance the
    // model across the rising edge. Entered and left #1 after a rising edge.
    task automatic tick(input string tag);
        logic exp_stall;
        logic [NUM_REGS-1:0] exp_mask;
        logic issue;
        exp_stall = in_v && !in_f &&
                    ((in_u1 && in_rs1 != 0 && cnt[in_rs1] != 0) ||
                     (in_u2 && in_rs2 != 0 && cnt[in_rs2] != 0));
        exp_mask = '0;
        for (int r = 1; r < NUM_REGS; r++) exp_mask[r] = (cnt[r] != 0);

        @(negedge clk);
        check({tag, ".stall"},   64'(sb_if.stall),        64'(exp_stall));
        check({tag, ".mask"},    64'(sb_if.pending_mask), 64'(exp_mask));
        check({tag, ".drained"}, 64'(sb_if.drained),      64'(exp_mask == '0));
        check({tag, ".scycles"}, 64'(sb_if.stall_cycles), 64'(sc));

        @(posedge clk);
        issue = in_v && !in_f && !exp_stall;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (issue && in_w && in_rd == r) cnt[r] = in_lat;
            else if (cnt[r] > 0)            cnt[r] = cnt[r] - 1;
        end
        if (exp_stall && sc < SC_MAX) sc++;
        #1;
    endtask

    initial begin
        model_reset();
        bubble();
        reset = 1'b1;
        #1;
        check("reset.stall",   64'(sb_if.stall),        64'(0));
        check("reset.mask",    64'(sb_if.pending_mask), 64'(0));
        check("reset.drained", 64'(sb_if.drained),      64'(1));
        check("reset.scycles", 64'(sb_if.stall_cycles), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;

        // Load-use: one stall cycle, then the consumer issues.
        drive(1, 0, 0, 0, 0, 0, 5, 1, LAT_LOAD);
        tick("lu.load");
        drive(1, 0, 5, 1, 0, 0, 10, 1, LAT_ALU);
        tick("lu.stall");
        tick("lu.issue");
        check("lu.scycles_one", 64'(sb_if.stall_cycles), 64'(1));
        bubble();
        tick("lu.idle");

        // ALU back-to-back never stalls and never shows pending.
        drive(1, 0, 0, 0, 0, 0, 7, 1, LAT_ALU);
        tick("alu.prod");
        drive(1, 0, 0, 0, 7, 1, 8, 1, LAT_ALU);
        tick("alu.cons");
        check("alu.mask_zero", 64'(sb_if.pending_mask), 64'(0));

        // WAW: a shorter younger latency replaces the older one.
        drive(1, 0, 0, 0, 0, 0, 3, 1, 3);
        tick("waw.first");
        drive(1, 0, 0, 0, 0, 0, 3, 1, 1);
        tick("waw.second");
        bubble();
        tick("waw.wait");
        check("waw.x3_clear", 64'(sb_if.pending_mask[3]), 64'(0));

        // Flush: no stall, no counter write, older producer keeps counting.
        drive(1, 0, 0, 0, 0, 0, 9, 1, 2);
        tick("fl.prod");
        drive(1, 1, 9, 1, 9, 1, 12, 1, 7);
        tick("fl.flushed");
        bubble();
        tick("fl.after");
        tick("fl.drain");
        check("fl.drained", 64'(sb_if.drained), 64'(1));

        // x0 destination and an unused operand.
        drive(1, 0, 0, 0, 0, 0, 0, 1, 3);
        tick("x0.write");
        check("x0.drained", 64'(sb_if.drained), 64'(1));
        drive(1, 0, 0, 0, 0, 0, 4, 1, 2);
        tick("unused.prod");
        drive(1, 0, 0, 0, 4, 0, 11, 0, 0);
        tick("unused.cons");
        bubble();
        repeat (2) tick("unused.drain");

        // Reset while a consumer is stalling.
        drive(1, 0, 0, 0, 0, 0, 6, 1, 3);
        tick("rst.prod");
        drive(1, 0, 6, 1, 0, 0, 13, 0, 0);
        tick("rst.stalling");
        #2 reset = 1'b1;
        #1;
        check("rst.stall",   64'(sb_if.stall),        64'(0));
        check("rst.mask",    64'(sb_if.pending_mask), 64'(0));
        check("rst.drained", 64'(sb_if.drained),      64'(1));
        check("rst.scycles", 64'(sb_if.stall_cycles), 64'(0));
        model_reset();
        bubble();
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;
        drive(1, 0, 6, 1, 0, 0, 13, 0, 0);
        tick("rst.reissue");

        // Long load-use stalls until stall_cycles saturates.
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 1, 7);
            tick("sat.prod");
            drive(1, 0, 1, 1, 0, 0, 2, 0, 0);
            repeat (8) tick("sat.cons");
        end
        check("sat.max", 64'(sb_if.stall_cycles), 64'(SC_MAX));

        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
